// File: rtl/cache_2way_wt_ctrl.sv
// cache_2way_wt_ctrl: 2-way set-associative write-through/write-allocate cache controller with per-set LRU; define PERF_CNT_EN for hit/miss counters
module cache_2way_wt_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SET_BITS = 6,
  parameter int OFFSET_BITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_wr_ack
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);
  localparam int TAG_W = ADDR_W - SET_BITS - OFFSET_BITS - 1;
  localparam int SETS = 1 << SET_BITS;
  localparam int LINES_WORDS = 1 << (SET_BITS + OFFSET_BITS);
  typedef enum logic [1:0] {IDLE, FILL, WRITE_THRU} state_t;
  state_t state_q, state_d;
  logic [1:0][SETS-1:0] valid_q, valid_d;
  logic [SETS-1:0] lru_q, lru_d;
  logic vic_q, vic_d;
  logic [TAG_W-1:0] ftag_q, ftag_d;
  logic [SET_BITS-1:0] fset_q, fset_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_mem [2][SETS];
  logic [DATA_W-1:0] data_mem [2][LINES_WORDS];
  logic [OFFSET_BITS-1:0] off;
  logic [SET_BITS-1:0] set;
  logic [TAG_W-1:0] tag;
  logic [1:0] hit_w;
  logic idle, hit_way, rd_hit, wr_hit, miss, fill_we, fill_last;
  assign off = cpu_addr[OFFSET_BITS:1];
  assign set = cpu_addr[OFFSET_BITS+SET_BITS:OFFSET_BITS+1];
  assign tag = cpu_addr[ADDR_W-1 -: TAG_W];
  assign hit_w = {valid_q[1][set] && tag_mem[1][set] == tag, valid_q[0][set] && tag_mem[0][set] == tag};
  assign hit_way = hit_w[1];
  assign idle = state_q == IDLE;
  assign rd_hit = idle & cpu_re & !cpu_we & |hit_w;
  assign wr_hit = idle & cpu_we & |hit_w;
  assign miss = idle & (cpu_re | cpu_we) & !(|hit_w);
  assign fill_we = state_q == FILL & mem_rvalid;
  assign fill_last = fill_we & &cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      lru_q <= '0;
      vic_q <= 1'b0;
      ftag_q <= '0;
      fset_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      lru_q <= lru_d;
      vic_q <= vic_d;
      ftag_q <= ftag_d;
      fset_q <= fset_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = miss ? FILL : wr_hit ? WRITE_THRU : fill_last ? IDLE :
              (state_q == WRITE_THRU && mem_wr_ack) ? IDLE : state_q;
  end
  always_comb begin
    valid_d = valid_q;
    lru_d = lru_q;
    vic_d = miss ? (valid_q[0][set] ? (valid_q[1][set] ? lru_q[set] : 1'b1) : 1'b0) : vic_q;
    ftag_d = miss ? tag : ftag_q;
    fset_d = miss ? set : fset_q;
    cnt_d = miss ? '0 : fill_we ? cnt_q + 1'b1 : cnt_q;
    if (rd_hit || wr_hit) lru_d[set] = !hit_way;
    if (fill_last) begin
      valid_d[vic_q][fset_q] = 1'b1;
      lru_d[fset_q] = !vic_q;
    end
  end
  always_comb begin
    stall = miss | wr_hit | state_q == FILL | (state_q == WRITE_THRU & !mem_wr_ack);
    cpu_rdata = rd_hit ? data_mem[hit_way][{set, off}] : '0;
    mem_rd_req = state_q == FILL;
    mem_wr_req = state_q == WRITE_THRU;
    mem_addr = state_q == FILL ? {ftag_q, fset_q, cnt_q, 1'b0} :
               state_q == WRITE_THRU ? cpu_addr & ~ADDR_W'(1) : '0;
    mem_wdata = state_q == WRITE_THRU ? cpu_wdata : '0;
  end
  always_ff @(posedge clk) begin
    if (wr_hit) data_mem[hit_way][{set, off}] <= cpu_wdata;
    if (fill_we) data_mem[vic_q][{fset_q, cnt_q}] <= mem_rdata;
    if (fill_last) tag_mem[vic_q][fset_q] <= ftag_q;
  end
`ifdef PERF_CNT_EN
  logic relook_q;
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  always_comb begin
    hit_cnt_d = hit_cnt_q + {15'd0, (rd_hit | wr_hit) & !relook_q & !(&hit_cnt_q)};
    miss_cnt_d = miss_cnt_q + {15'd0, miss & !(&miss_cnt_q)};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      relook_q <= 1'b0;
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      relook_q <= fill_last;
      hit_cnt_q <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
  assign hit_cnt = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_cache_2way_wt_ctrl.sv
// tb_cache_2way_wt_ctrl: scoreboard bench for cache_2way_wt_ctrl; build with PERF_CNT_EN defined to also check the counters
module tb_cache_2way_wt_ctrl;
  localparam int RD = 0, FL = 1, WT = 2;
  typedef struct {int kind; logic [15:0] a; logic [15:0] d;} ev_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0;
  logic cpu_re = 1'b0, cpu_we = 1'b0, mem_rvalid = 1'b0, mem_wr_ack = 1'b0;
  logic [15:0] cpu_rdata, mem_addr, mem_wdata;
  logic stall, mem_rd_req, mem_wr_req;
`ifdef PERF_CNT_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif
  int tests = 0, fails = 0, wcnt = 0;
  ev_t exp_q[$];
  logic [15:0] wmem [logic [15:0]];
  cache_2way_wt_ctrl dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall), .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_wr_ack(mem_wr_ack)
`ifdef PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] mem_word(logic [15:0] a);
    if (wmem.exists(a)) return wmem[a];
    return a[15:4] == 12'h123 ? 16'hA000 + {13'd0, a[3:1]} : {a[15:4], 1'b0, a[3:1]};
  endfunction
  task automatic observe(int kind, logic [15:0] a, logic [15:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: kind %0d addr %h data %h, none required", kind, a, d);
      return;
    end
    e = exp_q.pop_front();
    check("ev_kind", 16'(kind), 16'(e.kind));
    check("ev_addr", a, e.a);
    check("ev_data", d, e.d);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    wcnt = mem_wr_req ? wcnt + 1 : 0;
    mem_wr_ack = wcnt == 4;
    if (mem_wr_ack) wmem[mem_addr] = mem_wdata;
    mem_rvalid = mem_rd_req;
    mem_rdata = mem_rd_req ? mem_word(mem_addr) : 16'h0;
  end
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (cpu_re && !cpu_we && !stall) observe(RD, cpu_addr, cpu_rdata);
      if (mem_rd_req && mem_rvalid) observe(FL, mem_addr, 16'h0);
      if (mem_wr_req && mem_wr_ack) observe(WT, mem_addr, mem_wdata);
    end
  end
  task automatic access(logic we, logic [15:0] a, logic [15:0] d, logic miss, int lat);
    int n = 0;
    ev_t e;
    if (miss) for (int i = 0; i < 8; i++) begin
      e = '{FL, {a[15:4], 4'h0} + 16'(2 * i), 16'h0};
      exp_q.push_back(e);
    end
    e = we ? '{WT, a & 16'hFFFE, d} : '{RD, a, d};
    exp_q.push_back(e);
    cpu_addr = a;
    cpu_wdata = d;
    cpu_we = we;
    cpu_re = !we;
    @(negedge clk);
    while (stall && n < 40) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("latency_%h", a), 16'(n), 16'(lat));
    @(posedge clk);
    #1;
    cpu_re = 1'b0;
    cpu_we = 1'b0;
  endtask
  task automatic check_idle_outputs(string tag);
    check({tag, "_stall"}, {15'd0, stall}, 16'h0);
    check({tag, "_mem_rd_req"}, {15'd0, mem_rd_req}, 16'h0);
    check({tag, "_mem_wr_req"}, {15'd0, mem_wr_req}, 16'h0);
    check({tag, "_mem_addr"}, mem_addr, 16'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 16'h0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 16'h0);
`ifdef PERF_CNT_EN
    check({tag, "_hit_cnt"}, hit_cnt, 16'h0);
    check({tag, "_miss_cnt"}, miss_cnt, 16'h0);
`endif
  endtask
  initial begin
    int beats = 0, n = 0;
    ev_t e;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    access(1'b0, 16'h1234, 16'hA002, 1'b1, 9);
    access(1'b0, 16'h1236, 16'hA003, 1'b0, 0);
    access(1'b1, 16'h1234, 16'hBEEF, 1'b0, 4);
    access(1'b0, 16'h1234, 16'hBEEF, 1'b0, 0);
    access(1'b0, 16'h5634, 16'h5632, 1'b1, 9);
    access(1'b0, 16'h1234, 16'hBEEF, 1'b0, 0);
    access(1'b0, 16'h9A34, 16'h9A32, 1'b1, 9);
    access(1'b0, 16'h1234, 16'hBEEF, 1'b0, 0);
    access(1'b0, 16'h5634, 16'h5632, 1'b1, 9);
`ifdef PERF_CNT_EN
    check("miss_cnt", miss_cnt, 16'd4);
    check("hit_cnt", hit_cnt, 16'd5);
    force dut.hit_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.hit_cnt_q;
    access(1'b0, 16'h1234, 16'hBEEF, 1'b0, 0);
    check("hit_cnt_sat", hit_cnt, 16'hFFFF);
`endif
    for (int i = 0; i < 3; i++) begin
      e = '{FL, 16'h2000 + 16'(2 * i), 16'h0};
      exp_q.push_back(e);
    end
    cpu_addr = 16'h2000;
    cpu_re = 1'b1;
    while (beats < 3 && n < 40) begin
      @(negedge clk);
      if (mem_rd_req && mem_rvalid) beats++;
      n++;
    end
    check("fill_beats_before_reset", 16'(beats), 16'd3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_re = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midfill_reset");
    check("queue_after_reset", 16'(exp_q.size()), 16'd0);
    @(posedge clk);
    #1;
    access(1'b0, 16'h2000, 16'h2000, 1'b1, 9);
    access(1'b0, 16'h1236, 16'hA003, 1'b1, 9);
    access(1'b0, 16'h1234, 16'hBEEF, 1'b0, 0);
    repeat (3) @(posedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before 400000");
    $fatal(1);
  end
endmodule
